// File: rtl/uart_tx_arbiter_pkg.sv
// uart_ctrl_pkg: shared types for the UART TX arbiter slice.
// Holds the FSM state enum, byte type and link code constants.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER
  } state_t;

  typedef logic [7:0] byte_t;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: N_REQ byte-stream requester bundle.
// master = requesters (valid/data/last), slave = arbiter (ready).
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// req vector + last grantee -> first set index after last (wrapping), found.
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         found
);

  localparam logic [W:0] NN = (W+1)'(N);

  logic [W:0] idx;

  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, last} + (W+1)'(k);
      if (idx >= NN) idx = idx - NN;
      if (!found && req[idx[W-1:0]]) begin
        found  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX FIFO write port among N_REQ
// requesters (rr + packet lock) and owns baud/parity, applied on drain.
// Ports: clock, reset_n, req (slave), tx_fifo_full/empty, tx_active_flag,
// send, tx_data, cfg_wr/baud/parity, baud_rate, parity_type,
// cfg_pending, grant_valid, grant_id.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int         N_REQ      = 4,
  parameter int         MAX_BURST  = 16,
  parameter int         IDLE_TMO   = 64,
  parameter logic [1:0] DEF_BAUD   = BAUD_57600,
  parameter logic [1:0] DEF_PARITY = PAR_NONE,
  localparam int        GW         = $clog2(N_REQ)
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  req,
  input  logic              tx_fifo_full,
  input  logic              tx_fifo_empty,
  input  logic              tx_active_flag,
  output logic              send,
  output byte_t             tx_data,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_baud,
  input  logic [1:0]        cfg_parity,
  output logic [1:0]        baud_rate,
  output logic [1:0]        parity_type,
  output logic              cfg_pending,
  output logic              grant_valid,
  output logic [GW-1:0]     grant_id
);

  localparam byte_t BURST = byte_t'(MAX_BURST);
  localparam byte_t TMO   = byte_t'(IDLE_TMO);

  state_t           state, state_nx;
  logic [GW-1:0]    gid_nx, winner;
  logic             found;
  byte_t            beats, beats_nx;
  byte_t            idle, idle_nx;
  logic [N_REQ-1:0] ready;
  logic             g_valid, g_last, accept, apply;
  byte_t            g_data;
  logic [1:0]       pend_baud, pend_parity;

  uart_rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_pick (
    .req    (req.req_valid),
    .last   (grant_id),
    .winner (winner),
    .found  (found)
  );

  assign g_valid     = req.req_valid[grant_id];
  assign g_last      = req.req_last[grant_id];
  assign g_data      = req.req_data[{grant_id, 3'b000} +: 8];
  assign accept      = (state == XFER) && g_valid && !tx_fifo_full;
  assign grant_valid = (state != IDLE);
  assign req.req_ready = ready;

  // Settings only move while nothing of ours can be in flight.
  assign apply = cfg_pending && (state == IDLE)
              && tx_fifo_empty && !tx_active_flag;

  always_comb begin
    state_nx = state;
    gid_nx   = grant_id;
    beats_nx = beats;
    idle_nx  = idle;
    ready    = '0;
    send     = 1'b0;
    tx_data  = '0;
    unique case (state)
      IDLE: begin
        if (!cfg_pending && found) begin
          state_nx = GRANT;
          gid_nx   = winner;
        end
      end
      GRANT: begin
        state_nx = XFER;
        beats_nx = '0;
        idle_nx  = '0;
      end
      XFER: begin
        ready[grant_id] = !tx_fifo_full;
        send            = accept;
        tx_data         = accept ? g_data : '0;
        if (accept) begin
          beats_nx = beats + 1'b1;
          idle_nx  = '0;
          if (g_last || beats_nx == BURST) state_nx = IDLE;
        end else if (!tx_fifo_full) begin
          // Only a requester gap counts; a full FIFO freezes it.
          idle_nx = idle + 1'b1;
          if (idle_nx == TMO) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_id <= GW'(N_REQ - 1);
      beats    <= '0;
      idle     <= '0;
    end else begin
      state    <= state_nx;
      grant_id <= gid_nx;
      beats    <= beats_nx;
      idle     <= idle_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_rate   <= DEF_BAUD;
      parity_type <= DEF_PARITY;
      pend_baud   <= DEF_BAUD;
      pend_parity <= DEF_PARITY;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        pend_baud   <= cfg_baud;
        pend_parity <= cfg_parity;
      end
      if (apply) begin
        baud_rate   <= pend_baud;
        parity_type <= pend_parity;
      end
      // A write racing the apply stays pending.
      if (cfg_wr)     cfg_pending <= 1'b1;
      else if (apply) cfg_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and a
// randomized run scored against a transaction-level requester model.
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  vld, lst, rdy;
  logic [31:0] dat;
  logic        full, empty, active, send, cfg_wr;
  logic        cfg_pending, grant_valid;
  logic [7:0]  tx_data;
  logic [1:0]  cfg_baud, cfg_parity, baud_rate, parity_type;
  logic [1:0]  grant_id;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();
  assign bus.req_valid = vld;
  assign bus.req_last  = lst;
  assign bus.req_data  = dat;
  assign rdy = bus.req_ready;

  uart_tx_arbiter #(
    .N_REQ      (4),
    .MAX_BURST  (16),
    .IDLE_TMO   (64),
    .DEF_BAUD   (2'b10),
    .DEF_PARITY (2'b00)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (bus),
    .tx_fifo_full   (full),
    .tx_fifo_empty  (empty),
    .tx_active_flag (active),
    .send           (send),
    .tx_data        (tx_data),
    .cfg_wr         (cfg_wr),
    .cfg_baud       (cfg_baud),
    .cfg_parity     (cfg_parity),
    .baud_rate      (baud_rate),
    .parity_type    (parity_type),
    .cfg_pending    (cfg_pending),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t srcq[4][$];
  int    mg;
  int    glog[$];
  int    blog[$];

  function automatic int rr(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (last + k) % 4;
      if (v[2'(j)]) return j;
    end
    return last;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vld = '0; lst = '0; dat = '0;
    full = 1'b0; empty = 1'b1; active = 1'b0;
    cfg_wr = 1'b0; cfg_baud = '0; cfg_parity = '0;
    mg = 3;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  function automatic int qtotal();
    return srcq[0].size() + srcq[1].size()
         + srcq[2].size() + srcq[3].size();
  endfunction

  // Requesters present queue heads; the model tracks grant, beats
  // and the idle gap from the observable handshakes only.
  task automatic run(input int vp, input int fp, input int max_cyc);
    logic       pgv, rel, xfer, acc;
    logic [3:0] pv;
    int gc, beats, idle, cyc, acc_id;
    pgv = 0; rel = 0; pv = '0;
    gc = 0; beats = 0; idle = 0; cyc = 0;
    glog.delete();
    blog.delete();
    while ((qtotal() > 0 || grant_valid) && cyc < max_cyc) begin
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (srcq[i].size() > 0 && $urandom_range(99) < vp) begin
          vld[i] = 1'b1;
          dat[8*i +: 8] = srcq[i][0].d;
          lst[i] = srcq[i][0].l;
        end else begin
          vld[i] = 1'b0;
          dat[8*i +: 8] = 8'h00;
          lst[i] = 1'b0;
        end
      end
      full = ($urandom_range(99) < fp);
      @(negedge clock);
      if (pgv) chk("grant hold", grant_valid, !rel);
      else     chk("grant issue", grant_valid, pv != 0);
      if (grant_valid && !pgv) begin
        mg = rr(mg, pv);
        gc = 0; beats = 0; idle = 0;
        glog.push_back(mg);
        blog.push_back(0);
      end else if (grant_valid) begin
        gc++;
      end
      chk("grant id", grant_id, mg);
      xfer = grant_valid && gc >= 1;
      acc  = xfer && !full && vld[mg];
      chk("ready", rdy, (xfer && !full) ? (32'd1 << mg) : 32'd0);
      chk("send", send, acc);
      chk("tx data", tx_data, acc ? dat[8*mg +: 8] : 8'h00);
      rel = 0;
      acc_id = -1;
      if (acc) begin
        beats++;
        idle = 0;
        blog[blog.size()-1] = blog[blog.size()-1] + 1;
        acc_id = mg;
        if (lst[mg] || beats == 16) rel = 1;
      end else if (xfer && !full) begin
        idle++;
        if (idle == 64) rel = 1;
      end
      pgv = grant_valid;
      pv  = vld;
      tick();
      if (acc_id >= 0) void'(srcq[acc_id].pop_front());
    end
    chk("run within budget", cyc < max_cyc, 1);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        gv;
    logic [1:0]  gid;
    logic        snd;
    logic [7:0]  txd;
    logic [3:0]  rdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    int n, stall_snd, held, sent0, g1;
    beat_t bt;

    tbl[0]  = '{4'b0101, 4'b0100, 32'h00B1_00A1, 0, 0, 2'd3, 0, 8'h00, 4'b0000};
    tbl[1]  = '{4'b0101, 4'b0100, 32'h00B1_00A1, 0, 1, 2'd0, 0, 8'h00, 4'b0000};
    tbl[2]  = '{4'b0101, 4'b0100, 32'h00B1_00A1, 0, 1, 2'd0, 1, 8'hA1, 4'b0001};
    tbl[3]  = '{4'b0101, 4'b0100, 32'h00B1_00A2, 0, 1, 2'd0, 1, 8'hA2, 4'b0001};
    tbl[4]  = '{4'b0101, 4'b0101, 32'h00B1_00A3, 0, 1, 2'd0, 1, 8'hA3, 4'b0001};
    tbl[5]  = '{4'b0100, 4'b0100, 32'h00B1_0000, 0, 0, 2'd0, 0, 8'h00, 4'b0000};
    tbl[6]  = '{4'b0100, 4'b0100, 32'h00B1_0000, 0, 1, 2'd2, 0, 8'h00, 4'b0000};
    tbl[7]  = '{4'b0100, 4'b0100, 32'h00B1_0000, 1, 1, 2'd2, 0, 8'h00, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0100, 32'h00B1_0000, 0, 1, 2'd2, 1, 8'hB1, 4'b0100};
    tbl[9]  = '{4'b1001, 4'b1001, 32'hC100_00D1, 0, 0, 2'd2, 0, 8'h00, 4'b0000};
    tbl[10] = '{4'b1001, 4'b1001, 32'hC100_00D1, 0, 1, 2'd3, 0, 8'h00, 4'b0000};
    tbl[11] = '{4'b1001, 4'b1001, 32'hC100_00D1, 0, 1, 2'd3, 1, 8'hC1, 4'b1000};
    tbl[12] = '{4'b0001, 4'b0001, 32'h0000_00D1, 0, 0, 2'd3, 0, 8'h00, 4'b0000};
    tbl[13] = '{4'b0001, 4'b0001, 32'h0000_00D1, 0, 1, 2'd0, 0, 8'h00, 4'b0000};
    tbl[14] = '{4'b0001, 4'b0001, 32'h0000_00D1, 0, 1, 2'd0, 1, 8'hD1, 4'b0001};
    tbl[15] = '{4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 2'd0, 0, 8'h00, 4'b0000};

    // Reset values, with requests already pending.
    reset_n = 1'b0;
    vld = 4'b1111; lst = '0; dat = 32'hFFFF_FFFF;
    full = 1'b0; empty = 1'b1; active = 1'b0;
    cfg_wr = 1'b0; cfg_baud = '0; cfg_parity = '0;
    @(negedge clock);
    chk("rst grant_valid", grant_valid, 0);
    chk("rst grant_id", grant_id, 3);
    chk("rst send", send, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst ready", rdy, 0);
    chk("rst baud", baud_rate, 2'b10);
    chk("rst parity", parity_type, 2'b00);
    chk("rst cfg_pending", cfg_pending, 0);

    // Cycle-exact vectors: packet lock, fifo stall, rr order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      vld = tbl[i].v; lst = tbl[i].l;
      dat = tbl[i].d; full = tbl[i].f;
      @(negedge clock);
      chk($sformatf("row%0d grant_valid", i), grant_valid, tbl[i].gv);
      chk($sformatf("row%0d grant_id", i), grant_id, tbl[i].gid);
      chk($sformatf("row%0d send", i), send, tbl[i].snd);
      chk($sformatf("row%0d tx_data", i), tx_data, tbl[i].txd);
      chk($sformatf("row%0d ready", i), rdy, tbl[i].rdy);
      tick();
    end

    // Burst limit: req1 streams 20 bytes with no last, req2 one byte.
    do_reset();
    for (int b = 0; b < 20; b++) begin
      bt.d = 8'h40 + 8'(b);
      bt.l = 1'b0;
      srcq[1].push_back(bt);
    end
    bt.d = 8'hC0;
    bt.l = 1'b1;
    srcq[2].push_back(bt);
    run(100, 0, 400);
    chk("burst grants", glog.size(), 3);
    chk("burst g0", glog.size() > 0 ? glog[0] : -1, 1);
    chk("burst g1", glog.size() > 1 ? glog[1] : -1, 2);
    chk("burst g2", glog.size() > 2 ? glog[2] : -1, 1);
    chk("burst b0", blog.size() > 0 ? blog[0] : -1, 16);
    chk("burst b1", blog.size() > 1 ? blog[1] : -1, 1);
    chk("burst b2", blog.size() > 2 ? blog[2] : -1, 4);

    // Fifo stall then requester gap timeout on req3.
    do_reset();
    vld = 4'b1000; lst = '0; dat = 32'h3300_0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (grant_valid) break;
      tick();
    end
    chk("tmo grant", grant_valid && grant_id == 2'd3, 1);
    tick();
    @(negedge clock);
    chk("tmo first send", send, 1);
    chk("tmo first data", tx_data, 8'h33);
    tick();
    full = 1'b1;
    dat = 32'h3400_0000;
    stall_snd = 0;
    held = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (send) stall_snd++;
      if (grant_valid) held++;
      tick();
    end
    chk("stall sends", stall_snd, 0);
    chk("stall held", held, 10);
    full = 1'b0;
    vld = '0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!grant_valid) break;
      n++;
      tick();
    end
    chk("tmo cycles", n, 64);

    // Config change mid-packet, overwritten, applied on drain.
    do_reset();
    empty = 1'b0;
    active = 1'b1;
    vld = 4'b0011;
    lst = 4'b0010;
    dat = 32'h0000_11A1;
    sent0 = 0;
    g1 = 0;
    for (int c = 0; c < 20; c++) begin
      cfg_wr     = (c == 3 || c == 5);
      cfg_baud   = (c == 3) ? 2'b11 : 2'b01;
      cfg_parity = (c == 3) ? 2'b10 : 2'b01;
      @(negedge clock);
      if (rdy[0] && vld[0]) sent0++;
      if (grant_valid && grant_id == 2'd1) g1++;
      if (c == 4) begin
        chk("cfg pending mid", cfg_pending, 1);
        chk("cfg baud mid", baud_rate, 2'b10);
      end
      tick();
      vld[0] = (sent0 < 3);
      lst[0] = (sent0 == 2);
      dat[7:0] = 8'hA1 + 8'(sent0);
    end
    cfg_wr = 1'b0;
    chk("cfg pkt bytes", sent0, 3);
    chk("cfg no new grant", g1, 0);
    chk("cfg still pending", cfg_pending, 1);
    chk("cfg baud held", baud_rate, 2'b10);
    empty = 1'b1;
    tick();
    @(negedge clock);
    chk("cfg active blocks", cfg_pending, 1);
    tick();
    active = 1'b0;
    tick();
    @(negedge clock);
    chk("cfg baud applied", baud_rate, 2'b01);
    chk("cfg parity applied", parity_type, 2'b01);
    chk("cfg pending clr", cfg_pending, 0);
    chk("cfg gv at apply", grant_valid, 0);
    tick();
    @(negedge clock);
    chk("cfg grant after", grant_valid, 1);
    chk("cfg grant id", grant_id, 1);

    // Async reset while req1 is transferring.
    tick();
    @(negedge clock);
    chk("xfer send pre-rst", send, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst grant_valid", grant_valid, 0);
    chk("arst send", send, 0);
    chk("arst ready", rdy, 0);
    chk("arst baud", baud_rate, 2'b10);
    chk("arst parity", parity_type, 2'b00);
    chk("arst pending", cfg_pending, 0);

    // Randomized traffic with random fifo backpressure.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) begin
        n = $urandom_range(20, 1);
        for (int b = 0; b < n; b++) begin
          bt.d = 8'($urandom);
          bt.l = (b == n - 1);
          srcq[i].push_back(bt);
        end
      end
    end
    run(85, 20, 6000);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rand drained q%0d", i), srcq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
